// File: rtl/fir_gain_ctrl.sv
// Automatic gain controller for the FIR->DAC path: snoops accepted FIR output samples,
// tracks peak |sample| per window and steps the FIR wrapper's output shift up or down.
module fir_gain_ctrl #(
    parameter int DATA_W       = 32,
    parameter int SCALER       = 12,
    parameter int WINDOW_LEN   = 1024,
    parameter int SETTLE_LEN   = 128,
    parameter int HOLD_WINDOWS = 4,
    parameter int HI_THRESH    = 120,
    parameter int LO_THRESH    = 32,
    parameter int INIT_SHIFT   = 4
) (
    input  logic              s00_axis_aclk,
    input  logic              s00_axis_reset,
    input  logic              enable,
    input  logic [3:0]        manual_shift,
    input  logic              mon_tvalid,
    input  logic              mon_tready,
    input  logic [DATA_W-1:0] mon_tdata,
    output logic [3:0]        shift,
    output logic              shift_update,
    output logic              gain_limit,
    output logic [1:0]        ctrl_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        DECIDE  = 2'd2,
        SETTLE  = 2'd3
    } state_t;

    localparam int MAG_W   = DATA_W - 1;
    localparam int CNT_LEN = (WINDOW_LEN > SETTLE_LEN) ? WINDOW_LEN : SETTLE_LEN;
    localparam int CNT_W   = (CNT_LEN > 1) ? $clog2(CNT_LEN) : 1;
    localparam int QUIET_W = $clog2(HOLD_WINDOWS + 1);

    state_t             state, state_nx;
    logic [3:0]         shift_nx;
    logic               shift_update_nx;
    logic               gain_limit_nx;
    logic [MAG_W-1:0]   peak, peak_nx;
    logic [CNT_W-1:0]   sample_cnt, sample_cnt_nx;
    logic [QUIET_W-1:0] quiet_cnt, quiet_cnt_nx, quiet_inc;

    logic               accept;
    logic [DATA_W-1:0]  neg_data;
    logic [MAG_W-1:0]   mag;
    logic [MAG_W-1:0]   scaled;
    logic               too_loud;
    logic               too_quiet;

    assign accept   = mon_tvalid & mon_tready;
    assign neg_data = -mon_tdata;

    // Most negative input has no positive twin in MAG_W bits, so it saturates.
    always_comb begin
        if (!mon_tdata[DATA_W-1])
            mag = mon_tdata[MAG_W-1:0];
        else if (mon_tdata[MAG_W-1:0] == '0)
            mag = '1;
        else
            mag = neg_data[MAG_W-1:0];
    end

    assign scaled    = peak >> (SCALER + int'(shift));
    assign too_loud  = scaled > MAG_W'(HI_THRESH);
    assign too_quiet = scaled < MAG_W'(LO_THRESH);
    assign quiet_inc = (quiet_cnt == QUIET_W'(HOLD_WINDOWS)) ? quiet_cnt
                                                              : quiet_cnt + QUIET_W'(1);

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_nx        = state;
        shift_nx        = shift;
        shift_update_nx = 1'b0;
        gain_limit_nx   = gain_limit;
        peak_nx         = peak;
        sample_cnt_nx   = sample_cnt;
        quiet_cnt_nx    = quiet_cnt;

        if (!enable) begin
            state_nx      = IDLE;
            shift_nx      = manual_shift;
            peak_nx       = '0;
            sample_cnt_nx = '0;
            quiet_cnt_nx  = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    shift_nx      = manual_shift;
                    peak_nx       = '0;
                    sample_cnt_nx = '0;
                    quiet_cnt_nx  = '0;
                    state_nx      = MEASURE;
                end
                MEASURE: begin
                    if (accept) begin
                        if (mag > peak)
                            peak_nx = mag;
                        if (sample_cnt == CNT_W'(WINDOW_LEN - 1))
                            state_nx = DECIDE;
                        else
                            sample_cnt_nx = sample_cnt + CNT_W'(1);
                    end
                end
                DECIDE: begin
                    peak_nx       = '0;
                    sample_cnt_nx = '0;
                    state_nx      = MEASURE;
                    if (too_loud) begin
                        quiet_cnt_nx = '0;
                        if (shift != 4'd15) begin
                            shift_nx        = shift + 4'd1;
                            shift_update_nx = 1'b1;
                            state_nx        = SETTLE;
                        end else begin
                            gain_limit_nx = 1'b1;
                        end
                    end else if (too_quiet) begin
                        quiet_cnt_nx = quiet_inc;
                        if (quiet_inc == QUIET_W'(HOLD_WINDOWS) && shift != 4'd0) begin
                            shift_nx        = shift - 4'd1;
                            shift_update_nx = 1'b1;
                            quiet_cnt_nx    = '0;
                            state_nx        = SETTLE;
                        end
                    end else begin
                        quiet_cnt_nx = '0;
                    end
                end
                SETTLE: begin
                    if (accept) begin
                        if (sample_cnt == CNT_W'(SETTLE_LEN - 1)) begin
                            sample_cnt_nx = '0;
                            state_nx      = MEASURE;
                        end else begin
                            sample_cnt_nx = sample_cnt + CNT_W'(1);
                        end
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_reset) begin
            shift        <= 4'(INIT_SHIFT);
            shift_update <= 1'b0;
            gain_limit   <= 1'b0;
            peak         <= '0;
            sample_cnt   <= '0;
            quiet_cnt    <= '0;
        end else begin
            shift        <= shift_nx;
            shift_update <= shift_update_nx;
            gain_limit   <= gain_limit_nx;
            peak         <= peak_nx;
            sample_cnt   <= sample_cnt_nx;
            quiet_cnt    <= quiet_cnt_nx;
        end
    end

    assign ctrl_state = state;

endmodule

// File: tb/tb_fir_gain_ctrl.sv
// Directed bench for fir_gain_ctrl: table of measurement windows with hand-computed
// shift decisions, plus sequences for gain limit, enable abort, stalls and reset.
module tb_fir_gain_ctrl;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DECIDE  = 2'd2;
    localparam logic [1:0] ST_SETTLE  = 2'd3;

    logic        clk;
    logic        rst;
    logic        en_a, en_b;
    logic [3:0]  manual;
    logic        tvalid, tready;
    logic [31:0] tdata;
    logic [3:0]  shift_a, shift_b;
    logic        upd_a, upd_b, gl_a, gl_b;
    logic [1:0]  st_a, st_b;

    int n_chk = 0;
    int n_err = 0;

    fir_gain_ctrl #(
        .DATA_W(32), .SCALER(12), .WINDOW_LEN(16), .SETTLE_LEN(4), .HOLD_WINDOWS(2),
        .HI_THRESH(120), .LO_THRESH(32), .INIT_SHIFT(4)
    ) dut_a (
        .s00_axis_aclk(clk), .s00_axis_reset(rst), .enable(en_a), .manual_shift(manual),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tdata(tdata),
        .shift(shift_a), .shift_update(upd_a), .gain_limit(gl_a), .ctrl_state(st_a)
    );

    fir_gain_ctrl #(
        .DATA_W(32), .SCALER(0), .WINDOW_LEN(16), .SETTLE_LEN(4), .HOLD_WINDOWS(2),
        .HI_THRESH(120), .LO_THRESH(32), .INIT_SHIFT(4)
    ) dut_b (
        .s00_axis_aclk(clk), .s00_axis_reset(rst), .enable(en_b), .manual_shift(manual),
        .mon_tvalid(tvalid), .mon_tready(tready), .mon_tdata(tdata),
        .shift(shift_b), .shift_update(upd_b), .gain_limit(gl_b), .ctrl_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          reenable;
        logic [3:0]  manual;
        logic [31:0] data;
        logic [3:0]  exp_shift;
        logic        exp_pulse;
        logic [1:0]  exp_state;
    } win_t;

    win_t tbl[$];

    function automatic win_t mk(input bit re, input logic [3:0] m, input logic [31:0] d,
                                input logic [3:0] es, input logic ep, input logic [1:0] est);
        win_t w;
        w.reenable  = re;
        w.manual    = m;
        w.data      = d;
        w.exp_shift = es;
        w.exp_pulse = ep;
        w.exp_state = est;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are then stable and inputs may change safely.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sixteen accepted samples of d, with a stalled and an invalid beat mixed in
    // that carry full-scale data which must never reach the peak detector.
    task automatic run_window(input logic [31:0] d);
        for (int i = 0; i < 16; i++) begin
            if (i == 3) begin
                tvalid = 1'b1; tready = 1'b0; tdata = 32'h7fff_ffff;
                step();
                tvalid = 1'b0; tready = 1'b1; tdata = 32'h8000_0000;
                step();
            end
            tvalid = 1'b1; tready = 1'b1; tdata = d;
            step();
        end
        tvalid = 1'b0;
        tdata  = '0;
    endtask

    initial begin
        logic [3:0] cur;

        rst = 1'b1; en_a = 1'b0; en_b = 1'b0; manual = 4'd4;
        tvalid = 1'b0; tready = 1'b0; tdata = '0;
        step();
        step();
        check("reset shift", 32'(shift_a), 32'd4);
        check("reset shift_update", 32'(upd_a), 32'd0);
        check("reset gain_limit", 32'(gl_a), 32'd0);
        check("reset ctrl_state", 32'(st_a), 32'(ST_IDLE));

        rst = 1'b0;
        step();
        check("idle manual shift", 32'(shift_a), 32'd4);
        en_a = 1'b1;
        step();
        check("enable to measure", 32'(st_a), 32'(ST_MEASURE));
        cur = 4'd4;

        tbl.push_back(mk(0, 4'd0, 32'h0100_0000, 4'd5, 1'b1, ST_SETTLE));
        tbl.push_back(mk(0, 4'd0, 32'h0100_0000, 4'd6, 1'b1, ST_SETTLE));
        tbl.push_back(mk(0, 4'd0, 32'h0100_0000, 4'd6, 1'b0, ST_MEASURE));
        tbl.push_back(mk(1, 4'd4, 32'h0010_0000, 4'd4, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0010_0000, 4'd3, 1'b1, ST_SETTLE));
        tbl.push_back(mk(0, 4'd0, 32'h0010_0000, 4'd3, 1'b0, ST_MEASURE));
        tbl.push_back(mk(1, 4'd4, 32'h0010_0000, 4'd4, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0040_0000, 4'd4, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0010_0000, 4'd4, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0078_0000, 4'd4, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0079_0000, 4'd5, 1'b1, ST_SETTLE));
        tbl.push_back(mk(1, 4'd4, 32'h8000_0000, 4'd5, 1'b1, ST_SETTLE));
        tbl.push_back(mk(0, 4'd0, 32'hff00_0000, 4'd6, 1'b1, ST_SETTLE));
        tbl.push_back(mk(1, 4'd0, 32'h0000_0000, 4'd0, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0000_0000, 4'd0, 1'b0, ST_MEASURE));
        tbl.push_back(mk(0, 4'd0, 32'h0000_0000, 4'd0, 1'b0, ST_MEASURE));

        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].reenable) begin
                en_a = 1'b0; manual = tbl[k].manual;
                step();
                check($sformatf("w%0d abort state", k), 32'(st_a), 32'(ST_IDLE));
                check($sformatf("w%0d manual shift", k), 32'(shift_a), 32'(tbl[k].manual));
                en_a = 1'b1;
                step();
                cur = tbl[k].manual;
            end
            run_window(tbl[k].data);
            check($sformatf("w%0d decide state", k), 32'(st_a), 32'(ST_DECIDE));
            check($sformatf("w%0d shift in decide", k), 32'(shift_a), 32'(cur));
            step();
            check($sformatf("w%0d shift", k), 32'(shift_a), 32'(tbl[k].exp_shift));
            check($sformatf("w%0d pulse", k), 32'(upd_a), 32'(tbl[k].exp_pulse));
            check($sformatf("w%0d next state", k), 32'(st_a), 32'(tbl[k].exp_state));
            step();
            check($sformatf("w%0d pulse width", k), 32'(upd_a), 32'd0);
            if (tbl[k].exp_state == ST_SETTLE) begin
                for (int j = 0; j < 4; j++) begin
                    tvalid = 1'b1; tready = 1'b1; tdata = 32'h7fff_ffff;
                    step();
                    if (j == 2)
                        check($sformatf("w%0d settling", k), 32'(st_a), 32'(ST_SETTLE));
                end
                tvalid = 1'b0;
                check($sformatf("w%0d settle done", k), 32'(st_a), 32'(ST_MEASURE));
            end
            cur = tbl[k].exp_shift;
        end

        // Gain limit on the unscaled instance: increase requested at shift 15.
        en_a = 1'b0; manual = 4'd15;
        step();
        en_b = 1'b1;
        step();
        check("limit start state", 32'(st_b), 32'(ST_MEASURE));
        check("limit start shift", 32'(shift_b), 32'd15);
        check("limit start flag", 32'(gl_b), 32'd0);
        check("idle passes manual", 32'(shift_a), 32'd15);
        run_window(32'h0100_0000);
        check("limit decide", 32'(st_b), 32'(ST_DECIDE));
        step();
        check("limit shift", 32'(shift_b), 32'd15);
        check("limit no pulse", 32'(upd_b), 32'd0);
        check("limit flag", 32'(gl_b), 32'd1);
        check("limit state", 32'(st_b), 32'(ST_MEASURE));
        en_b = 1'b0;

        // Enable drop during DECIDE wins over the pending increase.
        manual = 4'd4; en_a = 1'b1;
        step();
        check("abort start", 32'(st_a), 32'(ST_MEASURE));
        run_window(32'h0100_0000);
        check("abort in decide", 32'(st_a), 32'(ST_DECIDE));
        en_a = 1'b0; manual = 4'd9;
        step();
        check("abort idle", 32'(st_a), 32'(ST_IDLE));
        check("abort shift", 32'(shift_a), 32'd9);
        check("abort no pulse", 32'(upd_a), 32'd0);
        step();
        check("abort still no pulse", 32'(upd_a), 32'd0);
        check("limit sticky", 32'(gl_b), 32'd1);

        // Back-pressure is not a sample; enable drop mid-window restarts from zero.
        en_a = 1'b1;
        step();
        check("stall start shift", 32'(shift_a), 32'd9);
        for (int i = 0; i < 100; i++) begin
            tvalid = 1'b1; tready = 1'b0; tdata = 32'h7fff_ffff;
            step();
        end
        check("stall state", 32'(st_a), 32'(ST_MEASURE));
        for (int i = 0; i < 8; i++) begin
            tvalid = 1'b1; tready = 1'b1; tdata = 32'h0100_0000;
            if (i == 7) begin
                en_a = 1'b0; manual = 4'd4;
            end
            step();
        end
        tvalid = 1'b0;
        check("mid drop state", 32'(st_a), 32'(ST_IDLE));
        check("mid drop shift", 32'(shift_a), 32'd4);
        en_a = 1'b1;
        step();
        check("restart state", 32'(st_a), 32'(ST_MEASURE));
        for (int i = 0; i < 16; i++) begin
            tvalid = 1'b1; tready = 1'b1; tdata = 32'h0040_0000;
            step();
            if (i == 14)
                check("restart count", 32'(st_a), 32'(ST_MEASURE));
        end
        tvalid = 1'b0;
        check("restart decide", 32'(st_a), 32'(ST_DECIDE));
        step();
        check("restart shift", 32'(shift_a), 32'd4);
        check("restart no pulse", 32'(upd_a), 32'd0);

        // Reset mid-window.
        for (int i = 0; i < 5; i++) begin
            tvalid = 1'b1; tready = 1'b1; tdata = 32'h0100_0000;
            step();
        end
        tvalid = 1'b0; manual = 4'd7; rst = 1'b1;
        step();
        check("mid reset state", 32'(st_a), 32'(ST_IDLE));
        check("mid reset shift", 32'(shift_a), 32'd4);
        check("reset clears limit", 32'(gl_b), 32'd0);
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
